uart_alu_engine: RTL and testbench
==================================

# uart_alu_engine

Parametrised command engine between the UART receiver and transmitter byte streams, and the successor to the fixed 32-bit UART multiplier. Each frame is one opcode byte followed by two big-endian operands of OPERAND_BYTES bytes. The engine computes MUL, ADD, SUB, MAC or CLR and returns a big-endian result of RESULT_BYTES bytes. It adds a persistent accumulator, an error response for bad opcodes, and an inter-byte timeout.

## Interface
- OPERAND_BYTES, default 4: operand size in bytes, legal range 1..8. W = 8*OPERAND_BYTES.
- RESULT_BYTES, default 4: response size in bytes, legal range 1..2*OPERAND_BYTES. Carries the low 8*RESULT_BYTES bits of the 2W-bit result.
- TIMEOUT_CYCLES, default 100000: idle-cycle limit inside a partial frame. 0 disables the timeout.
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- rx_data_i  input  8  received byte.
- rx_valid_i  input  1  rx_data_i valid.
- rx_ready_o  output  1  engine accepts a byte.
- tx_data_o  output  8  byte to transmit.
- tx_valid_o  output  1  tx_data_o valid.
- tx_ready_i  input  1  transmitter accepts the byte.
- busy_o  output  1  high whenever state != IDLE.
- err_o  output  1  one-cycle pulse on bad opcode or timeout.

## Operation
- Opcodes:
  - 0x00 MUL: unsigned a*b. Accumulator unchanged.
  - 0x01 ADD: a+b, zero-extended to 2W bits.
  - 0x02 SUB: a-b, two's complement in 2W bits.
  - 0x03 MAC: acc <= acc + a*b mod 2^(2W). Response is the new acc.
  - 0x04 CLR: acc <= 0. Response is 0.
- All valid opcodes consume both operands, including CLR, whose operands are ignored.
- Bad opcode (any other value): no operands are consumed. Response is the single byte 0xEE, and err_o pulses in the cycle the opcode is accepted.
- Accumulator is 2W bits wide. It resets to 0 only on rst_ni or CLR.
- States and transitions:
  - IDLE -> RX_A on a valid opcode accepted.
  - RX_A -> RX_B after OPERAND_BYTES bytes.
  - RX_B -> CALC after OPERAND_BYTES bytes.
  - CALC -> TX when the result is ready.
  - TX -> IDLE after the last byte handshakes.
  - IDLE -> ERR_TX on a bad opcode; ERR_TX -> IDLE after 0xEE handshakes.
- Operand bytes shift in MSB first.
- MUL and MAC use an iterative shift-add multiplier, one bit per cycle. No combinational W×W multiplier is allowed.
- Response bytes shift out MSB first.

## Timing
- Reset values: rx_ready_o=1, tx_valid_o=0, tx_data_o=0x00, busy_o=0, err_o=0, acc=0, state=IDLE.
- Reset asserted mid-frame aborts immediately. Partial operands are discarded and no response follows.
- rx_ready_o is high in IDLE, RX_A and RX_B, and low in all other states.
- A byte transfers on a cycle with rx_valid_i && rx_ready_o.
- CALC latency, counted from the cycle after the last operand byte to the first cycle of tx_valid_o:
  - W+1 cycles for MUL and MAC.
  - 1 cycle for ADD, SUB and CLR.
- In TX and ERR_TX, tx_valid_o stays high and tx_data_o stays stable until tx_valid_o && tx_ready_i. The next byte appears in the following cycle.
- tx_ready_i held low stalls TX indefinitely. Timeout does not apply in TX, ERR_TX or CALC.
- The state returns to IDLE, with rx_ready_o=1, in the cycle after the last TX handshake.
- Timeout counter:
  - Counts cycles without an accepted byte while in RX_A or RX_B.
  - Clears on each accepted byte.
  - On reaching TIMEOUT_CYCLES: pulse err_o, go to IDLE, discard the frame, emit no response. The accumulator is unchanged.
- ADD carry and SUB borrow land in bit W and above. They are visible only when RESULT_BYTES > OPERAND_BYTES.
- MAC wraps modulo 2^(2W) silently.

## Test plan
1. OPERAND_BYTES=4, RESULT_BYTES=4. Send 00 00000002 00000004 -> response 00 00 00 08. busy_o is low after the last byte.
2. RESULT_BYTES=8. Send 00 FFFFFFFF FFFFFFFF -> response FF FF FF FE 00 00 00 01. Check the CALC gap is 33 cycles.
3. Accumulator sequence:
   - 04 with any operands -> 00000000.
   - 03 00000003 00000005 -> 0000000F.
   - 03 00000007 00000002 -> 0000001D.
   - 00 00000002 00000002 -> 00000004, and the next MAC 03 00000001 00000001 -> 0000001E.
4. ADD and SUB:
   - 02 00000001 00000002 -> FF FF FF FF.
   - 01 FFFFFFFF 00000001 -> 00 00 00 00 with RESULT_BYTES=4.
   - The same ADD with RESULT_BYTES=8 -> 00 00 00 01 00 00 00 00.
   - Repeat all three with tx_ready_i toggling randomly; bytes must be identical and none dropped.
5. Bad opcode: send 7F -> err_o pulses once, response is the single byte EE, busy_o returns low. A following 00 00000002 00000004 frame -> 00 00 00 08.
6. Timeout and reset (TIMEOUT_CYCLES=50):
   - Send 00 AA BB, then stall 50 cycles -> err_o pulses, no tx_valid_o, next frame correct.
   - Assert rst_ni low during TX of a MAC response -> tx_valid_o=0 immediately. The next MAC 03 00000001 00000001 returns 00000001, showing acc was cleared.

Source files
------------

// File: rtl/uart_alu_engine.sv
// uart_alu_engine
//   Byte-stream command engine sitting between a UART receiver and transmitter.
//   A frame is one opcode byte followed by operand A and operand B, each
//   OPERAND_BYTES long and sent MSB first. The engine answers with the low
//   RESULT_BYTES of a 2W-bit result, also MSB first. It keeps a persistent
//   2W-bit accumulator (MAC/CLR). A bad opcode is answered with a single 0xEE
//   byte. A stalled partial frame is dropped after TIMEOUT_CYCLES idle cycles.
//
// Ports
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   rx_data_i   received byte, qualified by rx_valid_i / rx_ready_o
//   tx_data_o   byte to transmit, qualified by tx_valid_o / tx_ready_i
//   busy_o      high whenever the engine is not idle
//   err_o       one-cycle pulse on a bad opcode or on an inter-byte timeout
module uart_alu_engine #(
  parameter int OPERAND_BYTES  = 4,
  parameter int RESULT_BYTES   = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int W  = 8 * OPERAND_BYTES;
  localparam int W2 = 2 * W;
  localparam int RW = 8 * RESULT_BYTES;
  localparam logic [3:0]  OB_LAST  = 4'(OPERAND_BYTES - 1);
  localparam logic [4:0]  RB_LAST  = 5'(RESULT_BYTES - 1);
  localparam logic [6:0]  MUL_LAST = 7'(W);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MAC = 3'd3;
  localparam logic [2:0] OP_CLR = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RX_A   = 3'd1,
    RX_B   = 3'd2,
    CALC   = 3'd3,
    TX     = 3'd4,
    ERR_TX = 3'd5
  } state_t;

  state_t         state_r, state_s;
  logic [2:0]     op_r;
  logic [W-1:0]   a_r, b_r, mplier_r;
  logic [W2-1:0]  acc_r, prod_r, mcand_r;
  logic [RW-1:0]  out_r;
  logic [3:0]     byte_cnt_r;
  logic [4:0]     tx_cnt_r;
  logic [6:0]     calc_cnt_r;
  logic [31:0]    tmo_cnt_r;
  logic           rx_ready_r, tx_valid_r, busy_r;

  logic           rx_fire_s, tx_fire_s, op_ok_s, tmo_hit_s, in_rx_s;
  logic           is_mul_s, calc_done_s, err_s;
  logic [W2-1:0]  prod_sum_s, res_s;

  assign rx_ready_o = rx_ready_r;
  assign tx_valid_o = tx_valid_r;
  assign busy_o     = busy_r;
  assign tx_data_o  = out_r[RW-1 -: 8];
  // err_o must coincide with the opcode handshake, so it is the decoded pulse.
  assign err_o      = err_s;

  // Handshakes, opcode check, timeout detect and the datapath result mux.
  always_comb begin
    rx_fire_s   = rx_valid_i && rx_ready_r;
    tx_fire_s   = tx_valid_r && tx_ready_i;
    op_ok_s     = (rx_data_i <= 8'h04);
    in_rx_s     = (state_r == RX_A) || (state_r == RX_B);
    tmo_hit_s   = TMO_EN && in_rx_s && !rx_fire_s && (tmo_cnt_r == TMO_LAST);
    is_mul_s    = (op_r == OP_MUL) || (op_r == OP_MAC);
    // Final shift-add step folds in the last multiplier bit combinationally.
    prod_sum_s  = prod_r + (mplier_r[0] ? mcand_r : {W2{1'b0}});
    calc_done_s = (state_r == CALC) &&
                  (is_mul_s ? (calc_cnt_r == MUL_LAST) : (calc_cnt_r == 7'd0));
    case (op_r)
      OP_MUL:  res_s = prod_sum_s;
      OP_ADD:  res_s = W2'(a_r) + W2'(b_r);
      OP_SUB:  res_s = W2'(a_r) - W2'(b_r);
      OP_MAC:  res_s = acc_r + prod_sum_s;
      OP_CLR:  res_s = {W2{1'b0}};
      default: res_s = {W2{1'b0}};
    endcase
  end

  // Next-state logic and error pulse.
  always_comb begin
    state_s = state_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_fire_s) begin
          if (op_ok_s) begin
            state_s = RX_A;
          end else begin
            state_s = ERR_TX;
            err_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RX_A, RX_B: begin
        if (tmo_hit_s) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else if (rx_fire_s && (byte_cnt_r == OB_LAST)) begin
          state_s = (state_r == RX_A) ? RX_B : CALC;
        end else begin
          state_s = state_r;
        end
      end
      CALC: begin
        if (calc_done_s) state_s = TX;
        else             state_s = CALC;
      end
      TX: begin
        if (tx_fire_s && (tx_cnt_r == RB_LAST)) state_s = IDLE;
        else                                    state_s = TX;
      end
      ERR_TX: begin
        if (tx_fire_s) state_s = IDLE;
        else           state_s = ERR_TX;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      rx_ready_r <= 1'b1;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      rx_ready_r <= (state_s == IDLE) || (state_s == RX_A) || (state_s == RX_B);
      tx_valid_r <= (state_s == TX) || (state_s == ERR_TX);
      busy_r     <= (state_s != IDLE);
    end
  end

  // Frame capture: opcode, then operands shifted in MSB first; idle timer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_r       <= 3'd0;
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      byte_cnt_r <= 4'd0;
      tmo_cnt_r  <= 32'd0;
    end else begin
      if (state_r == IDLE) begin
        byte_cnt_r <= 4'd0;
        if (rx_fire_s) op_r <= rx_data_i[2:0];
        else           op_r <= op_r;
      end else if (in_rx_s && rx_fire_s) begin
        byte_cnt_r <= (byte_cnt_r == OB_LAST) ? 4'd0 : byte_cnt_r + 4'd1;
        if (state_r == RX_A) a_r <= (a_r << 8) | W'(rx_data_i);
        else                 b_r <= (b_r << 8) | W'(rx_data_i);
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end
      if (in_rx_s && !rx_fire_s) tmo_cnt_r <= tmo_cnt_r + 32'd1;
      else                       tmo_cnt_r <= 32'd0;
    end
  end

  // Shift-add multiplier: CALC cycle 0 loads, cycles 1..W add one bit each.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      calc_cnt_r <= 7'd0;
      prod_r     <= {W2{1'b0}};
      mcand_r    <= {W2{1'b0}};
      mplier_r   <= {W{1'b0}};
    end else if (state_r == CALC) begin
      calc_cnt_r <= calc_cnt_r + 7'd1;
      if (calc_cnt_r == 7'd0) begin
        prod_r   <= {W2{1'b0}};
        mcand_r  <= W2'(a_r);
        mplier_r <= b_r;
      end else begin
        prod_r   <= prod_sum_s;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
      end
    end else begin
      calc_cnt_r <= 7'd0;
    end
  end

  // Accumulator, response shift register and response byte counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_r    <= {W2{1'b0}};
      out_r    <= {RW{1'b0}};
      tx_cnt_r <= 5'd0;
    end else begin
      if (calc_done_s && ((op_r == OP_MAC) || (op_r == OP_CLR))) acc_r <= res_s;
      else                                                     acc_r <= acc_r;
      if (calc_done_s) begin
        out_r <= res_s[RW-1:0];
      end else if ((state_r == IDLE) && rx_fire_s && !op_ok_s) begin
        out_r <= RW'(8'hEE) << (RW - 8);
      end else if (tx_fire_s) begin
        out_r <= out_r << 8;
      end else begin
        out_r <= out_r;
      end
      if (state_r != TX)  tx_cnt_r <= 5'd0;
      else if (tx_fire_s) tx_cnt_r <= tx_cnt_r + 5'd1;
      else                tx_cnt_r <= tx_cnt_r;
    end
  end

endmodule

// File: tb/tb_uart_alu_engine.sv
module tb_uart_alu_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;

  logic       rdy0, txv0, busy0, err0, rdy1, txv1, busy1, err1;
  logic [7:0] txd0, txd1;
  logic       m_rdy, m_txv, m_busy, m_err;
  logic [7:0] m_txd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_cnt = 0;
  int err_cyc = 0;

  always #5 clk = ~clk;

  // dut0: 4-byte responses; dut1: 8-byte responses. Both time out after 50.
  uart_alu_engine #(.OPERAND_BYTES(4), .RESULT_BYTES(4), .TIMEOUT_CYCLES(50)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid && !sel),
    .rx_ready_o(rdy0), .tx_data_o(txd0), .tx_valid_o(txv0), .tx_ready_i(tx_ready && !sel),
    .busy_o(busy0), .err_o(err0));

  uart_alu_engine #(.OPERAND_BYTES(4), .RESULT_BYTES(8), .TIMEOUT_CYCLES(50)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid && sel),
    .rx_ready_o(rdy1), .tx_data_o(txd1), .tx_valid_o(txv1), .tx_ready_i(tx_ready && sel),
    .busy_o(busy1), .err_o(err1));

  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_txv  = sel ? txv1  : txv0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_err  = sel ? err1  : err0;
  assign m_txd  = sel ? txd1  : txd0;

  // Cycle counter and err_o pulse monitor for the selected engine.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    rx_data = b;
    rx_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!m_rdy && g < 500) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (m_rdy !== 1'b1) begin
      bad++;
      $display("FAIL send_byte: rx_ready=%b required 1 (byte %h)", m_rdy, b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8]);
  endtask

  // Collect n response bytes; gap counts non-valid cycles before the first byte.
  task automatic recv(input int n, input bit rnd, output logic [63:0] got, output int gap);
    int cnt, g;
    bit seen;
    got = 64'd0; gap = 0; cnt = 0; g = 0; seen = 1'b0;
    while (cnt < n && g < 3000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (m_txv) begin
        seen = 1'b1;
        if (tx_ready) begin
          got = {got[55:0], m_txd};
          cnt++;
        end
      end else if (!seen) begin
        gap++;
      end
      @(posedge clk); #1;
      g++;
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rdy0, txv0, txd0, busy0, err0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset dut0: rdy/txv/txd/busy/err=%b/%b/%h/%b/%b required 1/0/00/0/0",
               rdy0, txv0, txd0, busy0, err0);
    end
    total++;
    if ({rdy1, txv1, txd1, busy1, err1} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset dut1: rdy/txv/txd/busy/err=%b/%b/%h/%b/%b required 1/0/00/0/0",
               rdy1, txv1, txd1, busy1, err1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [63:0] got;
    int gap, e0;
    sel = 1'b0;
    e0 = err_cnt;
    send_frame(8'h00, 32'h2, 32'h4);
    recv(4, 1'b0, got, gap);
    total++;
    if (got[31:0] !== 32'h00000008) begin
      bad++; $display("FAIL mul_2x4: got %h required 00000008", got[31:0]);
    end
    total++;
    if (gap !== 33) begin
      bad++; $display("FAIL mul_gap: got %0d required 33", gap);
    end
    @(negedge clk);
    total++;
    if ({m_busy, m_rdy, m_txv} !== 3'b010) begin
      bad++; $display("FAIL mul_idle: busy/rdy/txv=%b%b%b required 010", m_busy, m_rdy, m_txv);
    end
    @(posedge clk); #1;
    total++;
    if (err_cnt - e0 !== 0) begin
      bad++; $display("FAIL mul_no_err: got %0d err pulses required 0", err_cnt - e0);
    end
  endtask

  task automatic test_wide_mul;
    logic [63:0] got;
    int gap;
    sel = 1'b1;
    send_frame(8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    recv(8, 1'b0, got, gap);
    total++;
    if (got !== 64'hFFFFFFFE00000001) begin
      bad++; $display("FAIL wide_mul: got %h required fffffffe00000001", got);
    end
    total++;
    if (gap !== 33) begin
      bad++; $display("FAIL wide_mul_gap: got %0d required 33", gap);
    end
    sel = 1'b0;
  endtask

  task automatic test_accumulator;
    logic [7:0]  ops [5] = '{8'h04, 8'h03, 8'h03, 8'h00, 8'h03};
    logic [31:0] av  [5] = '{32'h12345678, 32'h3, 32'h7, 32'h2, 32'h1};
    logic [31:0] bv  [5] = '{32'h9ABCDEF0, 32'h5, 32'h2, 32'h2, 32'h1};
    logic [31:0] exp [5] = '{32'h0, 32'hF, 32'h1D, 32'h4, 32'h1E};
    logic [63:0] got;
    int gap;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(ops[i], av[i], bv[i]);
      recv(4, 1'b0, got, gap);
      total++;
      if (got[31:0] !== exp[i]) begin
        bad++; $display("FAIL acc_step%0d: got %h required %h", i, got[31:0], exp[i]);
      end
    end
    send_frame(8'h04, 32'h0, 32'h0);
    recv(4, 1'b0, got, gap);
    total++;
    if (gap !== 1) begin
      bad++; $display("FAIL clr_gap: got %0d required 1", gap);
    end
  endtask

  task automatic test_add_sub(input bit rnd);
    logic [63:0] got;
    int gap;
    sel = 1'b0;
    send_frame(8'h02, 32'h1, 32'h2);
    recv(4, rnd, got, gap);
    total++;
    if (got[31:0] !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL sub_1m2 rnd=%0d: got %h required ffffffff", rnd, got[31:0]);
    end
    total++;
    if (gap !== 1) begin
      bad++; $display("FAIL sub_gap rnd=%0d: got %0d required 1", rnd, gap);
    end
    send_frame(8'h01, 32'hFFFFFFFF, 32'h1);
    recv(4, rnd, got, gap);
    total++;
    if (got[31:0] !== 32'h00000000) begin
      bad++; $display("FAIL add_carry4 rnd=%0d: got %h required 00000000", rnd, got[31:0]);
    end
    sel = 1'b1;
    send_frame(8'h01, 32'hFFFFFFFF, 32'h1);
    recv(8, rnd, got, gap);
    total++;
    if (got !== 64'h0000000100000000) begin
      bad++; $display("FAIL add_carry8 rnd=%0d: got %h required 0000000100000000", rnd, got);
    end
    sel = 1'b0;
  endtask

  task automatic test_bad_opcode;
    logic [63:0] got;
    int gap, e0;
    sel = 1'b0;
    e0 = err_cnt;
    send_byte(8'h7F);
    recv(1, 1'b0, got, gap);
    total++;
    if (got[7:0] !== 8'hEE) begin
      bad++; $display("FAIL bad_op_resp: got %h required ee", got[7:0]);
    end
    total++;
    if (err_cnt - e0 !== 1) begin
      bad++; $display("FAIL bad_op_err: got %0d pulses required 1", err_cnt - e0);
    end
    @(negedge clk);
    total++;
    if ({m_busy, m_rdy, m_txv} !== 3'b010) begin
      bad++; $display("FAIL bad_op_idle: busy/rdy/txv=%b%b%b required 010", m_busy, m_rdy, m_txv);
    end
    @(posedge clk); #1;
    send_frame(8'h00, 32'h2, 32'h4);
    recv(4, 1'b0, got, gap);
    total++;
    if (got[31:0] !== 32'h00000008) begin
      bad++; $display("FAIL bad_op_next: got %h required 00000008", got[31:0]);
    end
  endtask

  task automatic test_timeout;
    logic [63:0] got;
    int gap, e0, s;
    bit txseen;
    sel = 1'b0;
    e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    s = cyc;
    txseen = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (m_txv) txseen = 1'b1;
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    total++;
    if (err_cnt - e0 !== 1) begin
      bad++; $display("FAIL tmo_err: got %0d pulses required 1", err_cnt - e0);
    end
    total++;
    if (err_cyc - s !== 50) begin
      bad++; $display("FAIL tmo_pos: got idle cycle %0d required 50", err_cyc - s);
    end
    total++;
    if (txseen !== 1'b0 || m_busy !== 1'b0) begin
      bad++; $display("FAIL tmo_quiet: txseen=%b busy=%b required 0/0", txseen, m_busy);
    end
    send_frame(8'h00, 32'h2, 32'h4);
    recv(4, 1'b0, got, gap);
    total++;
    if (got[31:0] !== 32'h00000008) begin
      bad++; $display("FAIL tmo_next: got %h required 00000008", got[31:0]);
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [63:0] got;
    int gap, g;
    sel = 1'b0;
    send_frame(8'h03, 32'h5, 32'h6);
    g = 0;
    while (!m_txv && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    total++;
    if (m_txv !== 1'b1) begin
      bad++; $display("FAIL mac_tx_start: tx_valid=%b required 1", m_txv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({txv0, busy0, rdy0} !== 3'b001) begin
      bad++; $display("FAIL rst_mid_tx: txv/busy/rdy=%b%b%b required 001", txv0, busy0, rdy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h03, 32'h1, 32'h1);
    recv(4, 1'b0, got, gap);
    total++;
    if (got[31:0] !== 32'h00000001) begin
      bad++; $display("FAIL mac_after_rst: got %h required 00000001", got[31:0]);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_wide_mul;
    test_accumulator;
    test_add_sub(1'b0);
    test_add_sub(1'b1);
    test_bad_opcode;
    test_timeout;
    test_reset_mid_tx;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
